x_mux_trigger_sweep_ctrl: RTL

Sequencer for the x_mux_trigger tap-select datapath. It steps the mux select across a programmed tap range. At each tap it waits for the delay line to settle, then counts trigger hits over a fixed sampling window. Each per-tap result goes out on a valid/ready stream. The block sits between the calibration/UART control logic and the delay-line mux, and is clocked by the 12 MHz system clock.

---
 rtl/x_mux_trigger_sweep_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/x_mux_trigger_sweep_ctrl.sv
// x_mux_trigger_sweep_ctrl
//
// Steps the delay-line mux select across a programmed tap range. At every
// tap the select is held for SETTLE cycles so the delay line can settle.
// Trigger hits are then counted over WINDOW cycles, and the per-tap count is
// offered on a valid/ready result stream.
//
// Ports:
//   i_clk, i_nrst         system clock (rising edge), async active-low reset
//   i_start               start a sweep (only honoured in IDLE)
//   i_abort               synchronous abort, any state
//   i_first, i_last       tap range, captured on an accepted start
//   i_hit                 synchronous trigger observation
//   o_sel                 tap select to the mux
//   o_busy                sweep in progress (SETTLE/SAMPLE/REPORT)
//   o_done                one-cycle pulse at normal sweep completion
//   o_res_valid/i_res_ready, o_res_tap, o_res_count   per-tap result stream
module x_mux_trigger_sweep_ctrl #(
    parameter int SEL_W  = 5,
    parameter int SETTLE = 4,
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [SEL_W-1:0] i_first,
    input  logic [SEL_W-1:0] i_last,
    input  logic             i_hit,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [SEL_W-1:0] o_res_tap,
    output logic [CNT_W-1:0] o_res_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_REPORT
    } state_t;

    // Down-counters are loaded with N-1 and the state ends when they reach 0.
    // This gives exactly N edges in SETTLE and in SAMPLE.
    localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int WN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [ST_W-1:0] SETTLE_LOAD = ST_W'(SETTLE - 1);
    localparam logic [WN_W-1:0] WINDOW_LOAD = WN_W'(WINDOW - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;        // also holds the captured first tap
    logic [SEL_W-1:0]   last_q, last_d;
    logic [ST_W-1:0]    settle_q, settle_d;
    logic [WN_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]   hit_q, hit_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               res_valid_q, res_valid_d;
    logic [SEL_W-1:0]   res_tap_q, res_tap_d;
    logic [CNT_W-1:0]   res_count_q, res_count_d;
    logic [CNT_W-1:0]   hit_now;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            last_q      <= '0;
            settle_q    <= '0;
            win_q       <= '0;
            hit_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_tap_q   <= '0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            settle_q    <= settle_d;
            win_q       <= win_d;
            hit_q       <= hit_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_tap_q   <= res_tap_d;
            res_count_q <= res_count_d;
        end
    end

    // Next-state and datapath.
    // NOTE: every variable gets a default at the top so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        settle_d    = settle_q;
        win_d       = win_q;
        hit_d       = hit_q;
        done_d      = 1'b0;
        res_valid_d = res_valid_q;
        res_tap_d   = res_tap_q;
        res_count_d = res_count_q;

        // The count saturates at all-ones.
        hit_now = hit_q;
        if (i_hit && (hit_q != '1)) begin
            hit_now = hit_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_first <= i_last) begin
                        sel_d    = i_first;
                        last_d   = i_last;
                        settle_d = SETTLE_LOAD;
                        state_d  = S_SETTLE;
                    end else begin
                        // An empty range completes at once and produces no result.
                        done_d = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    hit_d   = '0;
                    win_d   = WINDOW_LOAD;
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q - ST_W'(1);
                end
            end
            S_SAMPLE: begin
                hit_d = hit_now;
                if (win_q == '0) begin
                    // The final window edge's hit is included in the result.
                    res_valid_d = 1'b1;
                    res_tap_d   = sel_q;
                    res_count_d = hit_now;
                    state_d     = S_REPORT;
                end else begin
                    win_d = win_q - WN_W'(1);
                end
            end
            S_REPORT: begin
                if (i_res_ready) begin
                    res_valid_d = 1'b0;
                    if (sel_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // No wrap possible: sel_q < last_q here.
                        sel_d    = sel_q + SEL_W'(1);
                        settle_d = SETTLE_LOAD;
                        state_d  = S_SETTLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything. A concurrent handshake still counts as
        // transferred, a concurrent start is dropped, and o_sel is held.
        if (i_abort) begin
            state_d     = S_IDLE;
            sel_d       = sel_q;
            last_d      = last_q;
            res_valid_d = 1'b0;
            done_d      = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // Outputs: registered state straight to the ports.
    always_comb begin
        o_sel       = sel_q;
        o_busy      = busy_q;
        o_done      = done_q;
        o_res_valid = res_valid_q;
        o_res_tap   = res_tap_q;
        o_res_count = res_count_q;
    end

endmodule
